row_access_seq: RTL

Sequencer directly upstream of the 5-to-32 row decoder in the 32-row array datapath. It accepts single-row access requests over a valid/ready handshake and fills idle time with background scan accesses. For each access it drives a stable 5-bit row address onto the decoder inputs and times the precharge and wordline-enable phases. It reports completion with a one-cycle `done` pulse.

---
 rtl/row_access_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/row_access_seq.sv
// row_access_seq: row decoder sequencer (request + background scan).
// Optional multi-row bursts are enabled by defining ROW_SEQ_BURST_EN.
module row_access_seq #(
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned WL_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_row,
  input  logic       req_we,
`ifdef ROW_SEQ_BURST_EN
  input  logic [4:0] req_len,
`endif
  input  logic       scan_en,
  output logic [4:0] row_addr,
  output logic       row_we,
  output logic       precharge,
  output logic       row_en,
  output logic       done,
  output logic       done_scan
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    WL,
    REL
  } state_t;

  localparam logic [3:0] PRE_LD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] WL_LD  = 4'(WL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] addr_q, addr_d;
  logic [4:0] sptr_q, sptr_d;
  logic       we_q, we_d;
  logic       scan_q, scan_d;
  logic       rdy_q, pre_q, ren_q;
  logic       done_q, dscan_q;
`ifdef ROW_SEQ_BURST_EN
  logic [4:0] left_q, left_d;
`endif

  // Next state, phase timing and access latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sptr_d  = sptr_q;
    we_d    = we_q;
    scan_d  = scan_q;
`ifdef ROW_SEQ_BURST_EN
    left_d  = left_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_row;
          we_d    = req_we;
          scan_d  = 1'b0;
          state_d = PRE;
          cnt_d   = PRE_LD;
`ifdef ROW_SEQ_BURST_EN
          left_d  = req_len;
`endif
        end else if (scan_en) begin
          addr_d  = sptr_q;
          we_d    = 1'b0;
          scan_d  = 1'b1;
          state_d = PRE;
          cnt_d   = PRE_LD;
`ifdef ROW_SEQ_BURST_EN
          left_d  = '0;
`endif
        end
      end
      PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = WL;
          cnt_d   = WL_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WL: begin
        if (cnt_q == 4'd0) begin
          state_d = REL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REL: begin
        state_d = IDLE;
        if (scan_q) begin
          sptr_d = sptr_q + 5'd1;
        end
`ifdef ROW_SEQ_BURST_EN
        if (left_q != 5'd0) begin
          state_d = PRE;
          cnt_d   = PRE_LD;
          addr_d  = addr_q + 5'd1;
          left_d  = left_q - 5'd1;
        end
`endif
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sptr_q  <= '0;
      we_q    <= 1'b0;
      scan_q  <= 1'b0;
      rdy_q   <= 1'b1;
      pre_q   <= 1'b0;
      ren_q   <= 1'b0;
      done_q  <= 1'b0;
      dscan_q <= 1'b0;
`ifdef ROW_SEQ_BURST_EN
      left_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sptr_q  <= sptr_d;
      we_q    <= we_d;
      scan_q  <= scan_d;
      rdy_q   <= (state_d == IDLE);
      pre_q   <= (state_d == PRE);
      ren_q   <= (state_d == WL);
      done_q  <= (state_d == REL);
      dscan_q <= (state_d == REL) && scan_d;
`ifdef ROW_SEQ_BURST_EN
      left_q  <= left_d;
`endif
    end
  end

  assign req_ready = rdy_q;
  assign row_addr  = addr_q;
  assign row_we    = we_q;
  assign precharge = pre_q;
  assign row_en    = ren_q;
  assign done      = done_q;
  assign done_scan = dscan_q;

endmodule
